nor_bist_ctrl: RTL and testbench
================================

Name: nor_bist_ctrl

Overview:
- Built-in self-test sequencer for a 2-input NOR gate instance (nor_b / nor_d / nor_g style, ports a, b, y).
- On a start pulse it drives the four input vectors 00, 01, 10, 11 onto the gate and waits a programmable settle time for each.
- It samples y for each vector, compares it against the expected NOR result and reports a per-vector fail mask plus an overall pass flag.
- Sits between a test host (start/abort/done) and the gate under test.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before y is sampled. Values below 1 are treated as 1.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a test run; honoured only in IDLE.
- abort  input  1  cancel the run in progress.
- dut_y  input  1  output y of the gate under test.
- dut_a  output  1  drives input a of the gate under test.
- dut_b  output  1  drives input b of the gate under test.
- busy  output  1  high while state is DRIVE or SAMPLE.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had no failures.
- fail_mask  output  4  bit i set when vector i failed; vector i = {dut_a, dut_b} = i.
- vec_idx  output  2  index of the vector currently driven.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - State goes to IDLE.
  - dut_a=0, dut_b=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0, settle counter=0.
  - Reset overrides all other inputs, including in the middle of a run.
- States:
  - IDLE: dut_a/dut_b held at 0.
    - start=1 and abort=0 -> DRIVE, vec_idx=0, fail_mask=0, pass=0, cnt=0.
  - DRIVE: {dut_a, dut_b}=vec_idx.
    - Each edge: if cnt==SETTLE_CYCLES-1 -> SAMPLE, otherwise cnt+1.
    - DRIVE therefore lasts exactly SETTLE_CYCLES cycles.
  - SAMPLE: lasts one cycle; vector still driven.
    - At the edge, fail_mask[vec_idx] <= (dut_y != ~(dut_a|dut_b)).
    - If vec_idx==3 -> DONE; otherwise vec_idx+1, cnt=0 -> DRIVE.
  - DONE: lasts one cycle.
    - done=1 and pass=(final fail_mask==0), including the bit written at the last SAMPLE.
    - dut_a=dut_b=0. Next state IDLE.
- Latency:
  - done is high in the cycle beginning 4*(SETTLE_CYCLES+1) edges after the edge that accepted start.
  - For the default this is 12 edges.
- Results:
  - fail_mask and pass hold their values after DONE until the next accepted start or reset.
  - Bits of fail_mask for vectors not yet sampled in the current run read 0.
- start handling:
  - start while busy or in DONE is ignored; no restart and no queuing.
  - start is level-sampled, so holding it high re-triggers a run from IDLE. A new run starts the cycle after DONE.
- abort:
  - In DRIVE or SAMPLE: next state IDLE; dut_a=dut_b=0, vec_idx=0, pass=0, no done pulse.
  - fail_mask keeps its partial contents.
  - abort in IDLE or DONE has no effect, except that DONE still completes normally.
  - start and abort together in IDLE: abort wins and the state stays IDLE.
- dut_y is sampled only at SAMPLE edges. Values of dut_y in other states are don't-care.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Golden NOR, SETTLE_CYCLES=2, single-cycle start:
  - vectors appear as 00, 01, 10, 11, each held 3 cycles;
  - done pulses 12 edges after start, pass=1, fail_mask=4'b0000.
- dut_y stuck at 0 -> fail_mask=4'b0001, pass=0. dut_y stuck at 1 -> fail_mask=4'b1110, pass=0.
- dut_y wired as OR(a,b) -> fail_mask=4'b1111, pass=0. Then rerun with the golden NOR -> fail_mask cleared at start, final pass=1.
- Abort asserted during the SAMPLE of vector 2 with dut_y stuck at 0:
  - state returns to IDLE next cycle, dut_a=dut_b=0, no done pulse;
  - fail_mask=4'b0001, pass=0.
- rst asserted in the middle of a run, plus start pulses while busy:
  - all outputs return to reset values on that edge;
  - start pulses during busy are ignored, so exactly one done per accepted start;
  - start and abort asserted together in IDLE -> stays IDLE.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=0:
  - both give 2 cycles per vector and done 8 edges after start.

Source files
------------

// File: rtl/nor_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input NOR gate: walks vectors 00..11,
// waits a settle time per vector, samples y and reports a fail mask and pass flag.
module nor_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    // A settle time of zero still needs one DRIVE cycle, so clamp it to 1.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       vec_nxt;
    logic [3:0]       mask_nxt;
    logic             pass_nxt;
    logic             drive_nxt;
    logic             sample_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vec_idx   <= 2'd0;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vec_idx   <= vec_nxt;
            fail_mask <= mask_nxt;
            pass      <= pass_nxt;
            dut_a     <= drive_nxt & vec_nxt[1];
            dut_b     <= drive_nxt & vec_nxt[0];
            busy      <= drive_nxt;
            done      <= (state_nxt == DONE);
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        vec_nxt     = vec_idx;
        mask_nxt    = fail_mask;
        pass_nxt    = pass;
        sample_fail = (dut_y != ~(vec_idx[1] | vec_idx[0]));

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                    vec_nxt   = 2'd0;
                    mask_nxt  = 4'd0;
                    pass_nxt  = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    vec_nxt   = 2'd0;
                    pass_nxt  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    vec_nxt   = 2'd0;
                    pass_nxt  = 1'b0;
                end else begin
                    mask_nxt[vec_idx] = sample_fail;
                    if (vec_idx == 2'd3) begin
                        state_nxt = DONE;
                        pass_nxt  = (mask_nxt == 4'd0);
                    end else begin
                        state_nxt = DRIVE;
                        vec_nxt   = vec_idx + 2'd1;
                        cnt_nxt   = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        drive_nxt = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
    end

endmodule

// File: tb/tb_nor_bist_ctrl.sv
// Directed bench for nor_bist_ctrl: gate models on dut_y, expected results
// queued at each start and scored when done pulses.
module tb_nor_bist_ctrl;

    localparam int M_NOR = 0;
    localparam int M_ST0 = 1;
    localparam int M_ST1 = 2;
    localparam int M_OR  = 3;

    typedef struct {
        logic [3:0] mask;
        logic       pass;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            abort;
    logic [2:0]      start_w;
    logic [2:0]      dut_y_w;
    logic [2:0]      dut_a_w;
    logic [2:0]      dut_b_w;
    logic [2:0]      busy_w;
    logic [2:0]      done_w;
    logic [2:0]      pass_w;
    logic [2:0][3:0] fail_mask_w;
    logic [2:0][1:0] vec_idx_w;

    int   y_mode;
    int   total;
    int   bad;
    int   done_count;
    int   dc;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic gate_y(input int mode, input logic a, input logic b);
        case (mode)
            M_NOR:   return ~(a | b);
            M_ST0:   return 1'b0;
            M_ST1:   return 1'b1;
            default: return a | b;
        endcase
    endfunction

    assign dut_y_w[0] = gate_y(y_mode, dut_a_w[0], dut_b_w[0]);
    assign dut_y_w[1] = gate_y(y_mode, dut_a_w[1], dut_b_w[1]);
    assign dut_y_w[2] = gate_y(y_mode, dut_a_w[2], dut_b_w[2]);

    nor_bist_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .abort(abort), .dut_y(dut_y_w[0]),
        .dut_a(dut_a_w[0]), .dut_b(dut_b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .fail_mask(fail_mask_w[0]), .vec_idx(vec_idx_w[0])
    );

    nor_bist_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .abort(abort), .dut_y(dut_y_w[1]),
        .dut_a(dut_a_w[1]), .dut_b(dut_b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .fail_mask(fail_mask_w[1]), .vec_idx(vec_idx_w[1])
    );

    nor_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .abort(abort), .dut_y(dut_y_w[2]),
        .dut_a(dut_a_w[2]), .dut_b(dut_b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .fail_mask(fail_mask_w[2]), .vec_idx(vec_idx_w[2])
    );

    always @(negedge clk) begin
        if (done_w[2] === 1'b1) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input int sel);
        checkOutput("rst_dut_a", dut_a_w[sel], 0);
        checkOutput("rst_dut_b", dut_b_w[sel], 0);
        checkOutput("rst_busy", busy_w[sel], 0);
        checkOutput("rst_done", done_w[sel], 0);
        checkOutput("rst_pass", pass_w[sel], 0);
        checkOutput("rst_fail_mask", fail_mask_w[sel], 0);
        checkOutput("rst_vec_idx", vec_idx_w[sel], 0);
    endtask

    // Select the gate model, queue what a full run should report, pulse start.
    task automatic applyStimulus(input int sel, input int mode, input bit expect_done);
        exp_t       e;
        logic [1:0] v;
        y_mode = mode;
        if (expect_done) begin
            e.mask = 4'd0;
            for (int i = 0; i < 4; i++) begin
                v = 2'(i);
                if (gate_y(mode, v[1], v[0]) !== ~(v[1] | v[0])) e.mask[i] = 1'b1;
            end
            e.pass = (e.mask == 4'd0);
            exp_q.push_back(e);
        end
        start_w[sel] = 1'b1;
        tick();
        start_w[sel] = 1'b0;
    endtask

    task automatic wait_and_score(input int sel, input int period, input bit poke);
        int         n;
        exp_t       e;
        logic [1:0] ev;
        checkOutput("mask_cleared", fail_mask_w[sel], 0);
        checkOutput("pass_cleared", pass_w[sel], 0);
        n = 0;
        while (done_w[sel] !== 1'b1 && n < 200) begin
            ev = 2'(n / period);
            checkOutput("drive_ab", {dut_a_w[sel], dut_b_w[sel]}, ev);
            checkOutput("vec_idx", vec_idx_w[sel], ev);
            checkOutput("busy_run", busy_w[sel], 1);
            start_w[sel] = poke && (n == 3 || n == 7);
            tick();
            n++;
        end
        start_w[sel] = 1'b0;
        checkOutput("latency", n, 4 * period);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.mask = 4'bxxxx;
            e.pass = 1'bx;
        end
        checkOutput("fail_mask", fail_mask_w[sel], e.mask);
        checkOutput("pass", pass_w[sel], e.pass);
        checkOutput("busy_done", busy_w[sel], 0);
        checkOutput("ab_done", {dut_a_w[sel], dut_b_w[sel]}, 0);
        tick();
        checkOutput("done_one_cycle", done_w[sel], 0);
        checkOutput("mask_hold", fail_mask_w[sel], e.mask);
        checkOutput("pass_hold", pass_w[sel], e.pass);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        done_count = 0;
        y_mode     = M_NOR;
        rst        = 1'b1;
        abort      = 1'b0;
        start_w    = 3'b000;
        tick();
        tick();
        check_reset_values(2);
        rst = 1'b0;
        tick();

        $display("[TB] golden and faulty gate runs, SETTLE_CYCLES=2");
        applyStimulus(2, M_NOR, 1);
        wait_and_score(2, 3, 0);
        applyStimulus(2, M_ST0, 1);
        wait_and_score(2, 3, 0);
        applyStimulus(2, M_ST1, 1);
        wait_and_score(2, 3, 0);
        applyStimulus(2, M_OR, 1);
        wait_and_score(2, 3, 0);
        applyStimulus(2, M_NOR, 1);
        wait_and_score(2, 3, 0);

        $display("[TB] abort during SAMPLE of vector 2");
        dc = done_count;
        applyStimulus(2, M_ST0, 0);
        repeat (8) tick();
        checkOutput("abort_pre_busy", busy_w[2], 1);
        checkOutput("abort_pre_vec", vec_idx_w[2], 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", busy_w[2], 0);
        checkOutput("abort_ab", {dut_a_w[2], dut_b_w[2]}, 0);
        checkOutput("abort_vec", vec_idx_w[2], 0);
        checkOutput("abort_pass", pass_w[2], 0);
        checkOutput("abort_mask", fail_mask_w[2], 4'b0001);
        repeat (20) tick();
        checkOutput("abort_no_done", done_count, dc);
        checkOutput("abort_idle", busy_w[2], 0);

        $display("[TB] reset mid-run and start while busy");
        dc = done_count;
        applyStimulus(2, M_NOR, 0);
        repeat (5) tick();
        start_w[2] = 1'b1;
        tick();
        start_w[2] = 1'b0;
        checkOutput("busy_start_ignored", vec_idx_w[2], 2);
        rst = 1'b1;
        tick();
        check_reset_values(2);
        rst = 1'b0;
        repeat (16) tick();
        checkOutput("rst_no_done", done_count, dc);

        applyStimulus(2, M_NOR, 1);
        wait_and_score(2, 3, 1);
        tick();
        checkOutput("one_done_per_start", done_count - dc, 1);

        start_w[2] = 1'b1;
        abort      = 1'b1;
        tick();
        checkOutput("start_abort_busy", busy_w[2], 0);
        checkOutput("start_abort_ab", {dut_a_w[2], dut_b_w[2]}, 0);
        start_w[2] = 1'b0;
        abort      = 1'b0;
        tick();
        checkOutput("start_abort_idle", busy_w[2], 0);

        $display("[TB] short settle instances");
        applyStimulus(1, M_NOR, 1);
        wait_and_score(1, 2, 0);
        applyStimulus(0, M_NOR, 1);
        wait_and_score(0, 2, 0);
        applyStimulus(0, M_ST1, 1);
        wait_and_score(0, 2, 0);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
